// File: rtl/mc_fifo_rr_merge.sv
// mc_fifo_rr_merge: per-channel FIFOs round-robin merged to one tagged stream; `MC_FIFO_RR_MERGE_OCC_EN adds occ port
module mc_fifo_rr_merge #(
  parameter int D_WIDTH = 6,
  parameter int A_WIDTH = 2,
  parameter int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*D_WIDTH-1:0]   up_data,
  input  logic [N_CH-1:0]           up_valid,
  output logic [N_CH-1:0]           up_ready,
  output logic [D_WIDTH-1:0]        down_data,
  output logic [CH_W-1:0]           down_ch,
  output logic                      down_valid,
  input  logic                      down_ready
`ifdef MC_FIFO_RR_MERGE_OCC_EN
  ,
  output logic [N_CH*(A_WIDTH+1)-1:0] occ
`endif
);
  localparam int DEPTH = 2**A_WIDTH;
  logic [D_WIDTH-1:0] mem [N_CH][DEPTH];
  logic [A_WIDTH-1:0] wr_ptr [N_CH];
  logic [A_WIDTH-1:0] rd_ptr [N_CH];
  logic [A_WIDTH:0] cnt [N_CH];
  logic [N_CH-1:0] push, pop, nonempty;
  logic load, grant;
  logic [CH_W-1:0] gidx, rr_ptr;
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      nonempty[i] = cnt[i] != '0;
      up_ready[i] = rst && !cnt[i][A_WIDTH];
    end
  end
  assign push = up_valid & up_ready;
  assign load = !down_valid || down_ready;
  // second pass overrides: channels above rr_ptr outrank the wrapped-around ones
  always_comb begin
    grant = 1'b0;
    gidx = '0;
    for (int i = N_CH-1; i >= 0; i--)
      if (nonempty[i] && i <= int'(rr_ptr)) begin
        grant = 1'b1;
        gidx = CH_W'(i);
      end
    for (int i = N_CH-1; i >= 0; i--)
      if (nonempty[i] && i > int'(rr_ptr)) begin
        grant = 1'b1;
        gidx = CH_W'(i);
      end
  end
  assign pop = {N_CH{load && grant}} & (N_CH'(1) << gidx);
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (!rst) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i] <= '0;
      end else begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= up_data[i*D_WIDTH +: D_WIDTH];
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + (A_WIDTH+1)'(push[i]) - (A_WIDTH+1)'(pop[i]);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      down_valid <= 1'b0;
      down_data <= '0;
      down_ch <= '0;
      rr_ptr <= CH_W'(N_CH-1);
    end else if (load) begin
      down_valid <= grant;
      if (grant) begin
        down_data <= mem[gidx][rd_ptr[gidx]];
        down_ch <= gidx;
        rr_ptr <= gidx;
      end
    end
  end
`ifdef MC_FIFO_RR_MERGE_OCC_EN
  for (genvar g = 0; g < N_CH; g++) begin : g_occ
    assign occ[g*(A_WIDTH+1) +: A_WIDTH+1] = cnt[g];
  end
`endif
endmodule

// File: tb/tb_mc_fifo_rr_merge.sv
// tb_mc_fifo_rr_merge: directed stimulus with a per-channel scoreboard and channel-order queue
module tb_mc_fifo_rr_merge;
  typedef struct packed {
    logic [1:0] ch;
    logic [5:0] d;
  } ent_t;
  logic clk, rst;
  logic [23:0] up_data;
  logic [3:0] up_valid, up_ready;
  logic [5:0] down_data;
  logic [1:0] down_ch;
  logic down_valid, down_ready;
`ifdef MC_FIFO_RR_MERGE_OCC_EN
  logic [11:0] occ;
`endif
  int n_chk = 0;
  int n_err = 0;
  ent_t sb[$];
  logic [1:0] ch_q[$];
  logic prev_stall = 1'b0;
  logic [5:0] prev_d;
  logic [1:0] prev_c;
  mc_fifo_rr_merge #(.D_WIDTH(6), .A_WIDTH(2), .N_CH(4)) dut (
    .clk(clk),
    .rst(rst),
    .up_data(up_data),
    .up_valid(up_valid),
    .up_ready(up_ready),
    .down_data(down_data),
    .down_ch(down_ch),
    .down_valid(down_valid),
    .down_ready(down_ready)
`ifdef MC_FIFO_RR_MERGE_OCC_EN
    ,
    .occ(occ)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (prev_stall && rst) begin
      n_chk++;
      if (!down_valid || down_data !== prev_d || down_ch !== prev_c) begin
        n_err++;
        $display("FAIL stall_hold: got v=%0d d=%0h c=%0d want v=1 d=%0h c=%0d",
                 down_valid, down_data, down_ch, prev_d, prev_c);
      end
    end
    prev_stall = rst && down_valid && !down_ready;
    prev_d = down_data;
    prev_c = down_ch;
    if (rst && down_valid && down_ready) begin
      int idx;
      idx = -1;
      for (int i = 0; i < sb.size(); i++)
        if (idx < 0 && sb[i].ch == down_ch) idx = i;
      n_chk++;
      if (idx < 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got ch=%0d d=%0h want none", down_ch, down_data);
      end else begin
        if (sb[idx].d !== down_data) begin
          n_err++;
          $display("FAIL sb_data ch%0d: got %0h want %0h", down_ch, down_data, sb[idx].d);
        end
        sb.delete(idx);
      end
      if (ch_q.size() > 0) begin
        n_chk++;
        if (ch_q[0] !== down_ch) begin
          n_err++;
          $display("FAIL rr_order: got %0d want %0d", down_ch, ch_q[0]);
        end
        void'(ch_q.pop_front());
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [3:0] v, input logic [23:0] d);
    up_valid = v;
    up_data = d;
    tick();
    up_valid = '0;
  endtask
  task automatic exp_w(input logic [1:0] c, input logic [5:0] d, input bit order);
    sb.push_back('{ch: c, d: d});
    if (order) ch_q.push_back(c);
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 40 && (sb.size() > 0 || ch_q.size() > 0); i++) tick();
    check(name, sb.size() + ch_q.size(), 0);
  endtask
  task automatic rst_pulse();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask
  initial begin
    rst = 1'b0;
    up_valid = '0;
    up_data = '0;
    down_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", down_valid, 0);
    check("rst_data", down_data, 0);
    check("rst_ch", down_ch, 0);
    check("rst_up_ready", up_ready, 0);
    rst = 1'b1;
    #1;
    check("post_rst_up_ready", up_ready, 4'hf);
    exp_w(2, 6'h15, 1);
    put(4'b0100, {6'h0, 6'h15, 6'h0, 6'h0});
    check("lat_t", down_valid, 0);
    tick();
    check("lat_t1_valid", down_valid, 1);
    check("lat_t1_data", down_data, 6'h15);
    check("lat_t1_ch", down_ch, 2);
    tick();
    check("lat_t2_valid", down_valid, 0);
    down_ready = 1'b0;
    exp_w(1, 6'h3f, 1);
    put(4'b0010, {6'h0, 6'h0, 6'h3f, 6'h0});
    for (int i = 1; i <= 4; i++) begin
      check("fill_ready", up_ready[0], 1);
      exp_w(0, 6'(i), 1);
      put(4'b0001, {18'h0, 6'(i)});
    end
    check("full_ready", up_ready[0], 0);
`ifdef MC_FIFO_RR_MERGE_OCC_EN
    check("full_occ", occ[2:0], 4);
`endif
    put(4'b0001, {18'h0, 6'h05});
    check("refused_ready", up_ready[0], 0);
    check("stall_data", down_data, 6'h3f);
    down_ready = 1'b1;
    tick();
    check("ready_after_pop", up_ready[0], 1);
    drain("drain_fill");
    rst_pulse();
    down_ready = 1'b0;
    put(4'b1111, {6'h13, 6'h12, 6'h11, 6'h10});
    put(4'b1111, {6'h23, 6'h22, 6'h21, 6'h20});
    for (int i = 0; i < 4; i++) exp_w(2'(i), 6'h10 + 6'(i), 1);
    for (int i = 0; i < 4; i++) exp_w(2'(i), 6'h20 + 6'(i), 1);
    down_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("rr_no_gap", down_valid, 1);
      tick();
    end
    check("rr_end", down_valid, 0);
    drain("drain_rr");
    rst_pulse();
    down_ready = 1'b0;
    exp_w(1, 6'h01, 1);
    exp_w(3, 6'h03, 1);
    exp_w(1, 6'h02, 1);
    put(4'b0010, {6'h0, 6'h0, 6'h01, 6'h0});
    put(4'b1010, {6'h03, 6'h0, 6'h02, 6'h0});
    down_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("skip_no_bubble", down_valid, 1);
      tick();
    end
    check("skip_end", down_valid, 0);
    drain("drain_skip");
    exp_w(2, 6'h32, 1);
    exp_w(0, 6'h30, 1);
    exp_w(2, 6'h33, 1);
    exp_w(0, 6'h31, 1);
    put(4'b0101, {6'h0, 6'h32, 6'h0, 6'h30});
    put(4'b0101, {6'h0, 6'h33, 6'h0, 6'h31});
    down_ready = 1'b0;
    tick();
    tick();
    check("stall_valid", down_valid, 1);
    down_ready = 1'b1;
    drain("drain_stall");
    down_ready = 1'b0;
    put(4'b0010, {6'h0, 6'h0, 6'h0a, 6'h0});
    put(4'b0010, {6'h0, 6'h0, 6'h0b, 6'h0});
    put(4'b0010, {6'h0, 6'h0, 6'h0c, 6'h0});
    put(4'b0010, {6'h0, 6'h0, 6'h0d, 6'h0});
    check("pre_rst_valid", down_valid, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_up_ready", up_ready, 0);
    tick();
    check("mid_rst_valid", down_valid, 0);
    check("mid_rst_data", down_data, 0);
    check("mid_rst_ch", down_ch, 0);
`ifdef MC_FIFO_RR_MERGE_OCC_EN
    check("mid_rst_occ", occ, 0);
`endif
    rst = 1'b1;
    down_ready = 1'b1;
    #1;
    check("rel_up_ready", up_ready, 4'hf);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stale", down_valid, 0);
    end
    exp_w(3, 6'h2a, 1);
    put(4'b1000, {6'h2a, 18'h0});
    drain("drain_final");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
